pipeline_hazard_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage RV32 pipeline. It detects load-use hazards between Decode and the ID/EX register and squashes wrong-path instructions on taken branches/jumps resolved in Execute. It also freezes the whole pipeline while data memory holds off a MEM-stage access. It drives the stall (hold) and flush (bubble) controls of the IF/ID, ID/EX, EX/MEM and MEM/WB registers; forwarding stays in the forwarding unit.

---
 rtl/pipeline_hazard_controller.sv | 185 ++++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
//   Central stall/flush sequencer for the 5-stage RV32 pipeline.
//   - Load-use hazard between Decode and ID/EX: one-cycle stall of PC and IF/ID
//     plus a bubble into ID/EX.
//   - Taken branch/jump resolved in Execute: squash IF/ID and ID/EX.
//   - Data-memory hold-off of a MEM access: freeze PC..EX/MEM and bubble MEM/WB,
//     bounded by MEM_TIMEOUT wait cycles before entering a sticky ERROR state.
//   Optional feature macro: HAZARD_PERF_CNT_EN (saturating performance counters).
//   When it is undefined, LoadUseCount/FlushCount/MemWaitCount read as 0.
module pipeline_hazard_controller #(
    parameter int MEM_TIMEOUT = 255,
    parameter int WAIT_W      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic        UsesRs1D,
    input  logic        UsesRs2D,
    input  logic [4:0]  WriteAddressD2E,
    input  logic        MemReadD2E,
    input  logic        PCSelectE,
    input  logic        MemReqM,
    input  logic        MemReadyM,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic        MemTimeout,
    output logic [1:0]  StateOut,
    output logic [31:0] LoadUseCount,
    output logic [31:0] FlushCount,
    output logic [31:0] MemWaitCount
);

    localparam logic [1:0] S_RUN  = 2'b00;
    localparam logic [1:0] S_WAIT = 2'b01;
    localparam logic [1:0] S_ERR  = 2'b10;

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

    logic [1:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;

    logic load_use;
    logic mem_hold;
    logic rs1_hit;
    logic rs2_hit;

    // Hazard detection: x0 is never a real producer, so it cannot create a hazard.
    assign rs1_hit  = UsesRs1D && (Rs1D == WriteAddressD2E);
    assign rs2_hit  = UsesRs2D && (Rs2D == WriteAddressD2E);
    assign load_use = MemReadD2E && (WriteAddressD2E != 5'd0) && (rs1_hit || rs2_hit);
    assign mem_hold = MemReqM && !MemReadyM;

    // State register: FSM state, wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic: enter MEM_WAIT on a held-off access, leave on ready,
    // give up into ERROR once the wait counter has reached MEM_TIMEOUT.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        case (state_q)
            S_RUN: begin
                if (mem_hold) begin
                    state_d = S_WAIT;
                    wait_d  = WAIT_ONE;
                end
            end
            S_WAIT: begin
                if (MemReadyM) begin
                    state_d = S_RUN;
                    wait_d  = '0;
                end else if (wait_q == WAIT_LIMIT) begin
                    // Counter holds at the limit rather than wrapping.
                    state_d   = S_ERR;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end
            S_ERR: begin
                timeout_d = 1'b1;
            end
            default: begin
                state_d = S_RUN;
                wait_d  = '0;
            end
        endcase
    end

    // Output logic (Mealy): freeze while memory holds off, otherwise branch
    // squash outranks load-use because the Decode instruction is discarded anyway.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (!reset) begin
            case (state_q)
                S_RUN, S_WAIT: begin
                    // In MEM_WAIT the access is still outstanding even if
                    // MemReqM has dropped, so only MemReadyM releases the freeze.
                    if ((state_q == S_RUN) ? mem_hold : !MemReadyM) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        StallE = 1'b1;
                        StallM = 1'b1;
                        FlushW = 1'b1;
                    end else if (PCSelectE) begin
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                    end else if (load_use) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end
                end
                S_ERR: begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    StallM = 1'b1;
                    FlushW = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign StateOut   = reset ? S_RUN : state_q;
    assign MemTimeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] lu_cnt_q, fl_cnt_q, mw_cnt_q;
    logic        lu_evt, fl_evt, mw_evt;

    // Only load-use raises StallF without StallE; only a branch raises FlushD.
    assign lu_evt = StallF && !StallE;
    assign fl_evt = FlushD;
    assign mw_evt = FlushW;

    // Saturating performance counters, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            lu_cnt_q <= '0;
            fl_cnt_q <= '0;
            mw_cnt_q <= '0;
        end else begin
            if (lu_evt && (lu_cnt_q != 32'hFFFF_FFFF)) lu_cnt_q <= lu_cnt_q + 32'd1;
            if (fl_evt && (fl_cnt_q != 32'hFFFF_FFFF)) fl_cnt_q <= fl_cnt_q + 32'd1;
            if (mw_evt && (mw_cnt_q != 32'hFFFF_FFFF)) mw_cnt_q <= mw_cnt_q + 32'd1;
        end
    end

    assign LoadUseCount = lu_cnt_q;
    assign FlushCount   = fl_cnt_q;
    assign MemWaitCount = mw_cnt_q;
`else
    assign LoadUseCount = 32'd0;
    assign FlushCount   = 32'd0;
    assign MemWaitCount = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed vectors, a behavioural model
// checked every cycle on the falling edge, plus hand-computed literal checks.
module tb_pipeline_hazard_controller;

    localparam int TO = 4;
`ifdef HAZARD_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  Rs1D, Rs2D, WriteAddressD2E;
    logic        UsesRs1D, UsesRs2D, MemReadD2E, PCSelectE, MemReqM, MemReadyM;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
    logic [1:0]  StateOut;
    logic [31:0] LoadUseCount, FlushCount, MemWaitCount;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    pipeline_hazard_controller #(.MEM_TIMEOUT(TO), .WAIT_W(8)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .UsesRs1D(UsesRs1D), .UsesRs2D(UsesRs2D),
        .WriteAddressD2E(WriteAddressD2E), .MemReadD2E(MemReadD2E),
        .PCSelectE(PCSelectE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .MemTimeout(MemTimeout), .StateOut(StateOut),
        .LoadUseCount(LoadUseCount), .FlushCount(FlushCount), .MemWaitCount(MemWaitCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 running, 1 waiting on memory, 2 timed out.
    int          m_mode = 0;
    int          m_wait = 0;
    bit          m_to   = 1'b0;
    int unsigned m_lu = 0, m_fl = 0, m_mw = 0;

    always @(negedge clk) begin
        bit hz, frz, br, lu;
        if (mon_en) begin
            hz  = MemReadD2E && (WriteAddressD2E != 0) &&
                  ((UsesRs1D && Rs1D == WriteAddressD2E) || (UsesRs2D && Rs2D == WriteAddressD2E));
            frz = 0; br = 0; lu = 0;
            if (!reset) begin
                if (m_mode == 2 || (m_mode == 0 && MemReqM && !MemReadyM) || (m_mode == 1 && !MemReadyM))
                    frz = 1;
                else if (PCSelectE) br = 1;
                else if (hz) lu = 1;
            end
            chk("m_StallF", StallF, frz | lu);
            chk("m_StallD", StallD, frz | lu);
            chk("m_StallE", StallE, frz);
            chk("m_StallM", StallM, frz);
            chk("m_FlushD", FlushD, br);
            chk("m_FlushE", FlushE, br | lu);
            chk("m_FlushW", FlushW, frz);
            chk("m_StateOut", StateOut, reset ? 0 : m_mode);
            chk("m_MemTimeout", MemTimeout, m_to);
            chk("m_LoadUseCount", LoadUseCount, PERF ? m_lu : 0);
            chk("m_FlushCount", FlushCount, PERF ? m_fl : 0);
            chk("m_MemWaitCount", MemWaitCount, PERF ? m_mw : 0);
            // advance model to the state after the coming rising edge
            if (reset) begin
                m_mode = 0; m_wait = 0; m_to = 0; m_lu = 0; m_fl = 0; m_mw = 0;
            end else begin
                m_lu += lu; m_fl += br; m_mw += frz;
                if (m_mode == 0 && MemReqM && !MemReadyM) begin
                    m_mode = 1; m_wait = 1;
                end else if (m_mode == 1) begin
                    if (MemReadyM) begin m_mode = 0; m_wait = 0; end
                    else if (m_wait >= TO) begin m_mode = 2; m_to = 1; end
                    else m_wait++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Rs1D = 0; Rs2D = 0; UsesRs1D = 0; UsesRs2D = 0; WriteAddressD2E = 0;
        MemReadD2E = 0; PCSelectE = 0; MemReqM = 0; MemReadyM = 0;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                          input logic [4:0] r2, input logic u2);
        MemReadD2E = 1; WriteAddressD2E = rd; Rs1D = r1; UsesRs1D = u1; Rs2D = r2; UsesRs2D = u2;
    endtask

    initial begin
        idle();
        reset = 1;
        tick();
        mon_en = 1;
        tick();
        reset = 0; #1;
        chk("rst_StateOut", StateOut, 0);
        chk("rst_StallF", StallF, 0);
        chk("rst_MemTimeout", MemTimeout, 0);
        chk("rst_MemWaitCount", MemWaitCount, 0);

        // load to x5, Decode reads x5 via rs1
        tick(); set_lu(5, 5, 1, 0, 0); #1;
        chk("lu_StallF", StallF, 1);
        chk("lu_StallD", StallD, 1);
        chk("lu_FlushE", FlushE, 1);
        chk("lu_StallE", StallE, 0);
        tick(); idle(); #1;
        chk("lu_after_StallF", StallF, 0);
        chk("lu_LoadUseCount", LoadUseCount, PERF ? 1 : 0);

        // destination x0: no hazard
        tick(); set_lu(0, 0, 1, 0, 1); #1;
        chk("x0_StallF", StallF, 0);
        // rs2 hit, and rs2 not used
        tick(); set_lu(7, 3, 1, 7, 1); #1;
        chk("rs2_StallD", StallD, 1);
        tick(); set_lu(7, 3, 1, 7, 0); #1;
        chk("rs2_unused_StallD", StallD, 0);
        // no load in ID/EX
        tick(); set_lu(9, 9, 1, 0, 0); MemReadD2E = 0; #1;
        chk("noload_StallF", StallF, 0);

        // branch outranks load-use
        tick(); set_lu(5, 5, 1, 0, 0); PCSelectE = 1; #1;
        chk("br_FlushD", FlushD, 1);
        chk("br_FlushE", FlushE, 1);
        chk("br_StallF", StallF, 0);
        chk("br_StallD", StallD, 0);

        // memory held off 3 cycles then ready
        tick(); idle(); MemReqM = 1; #1;
        chk("mw0_StateOut", StateOut, 0);
        chk("mw0_StallM", StallM, 1);
        chk("mw0_FlushW", FlushW, 1);
        tick(); PCSelectE = 1; #1;
        chk("mw1_StateOut", StateOut, 1);
        chk("mw1_StallF", StallF, 1);
        chk("mw1_br_ignored", FlushD, 0);
        tick(); PCSelectE = 0; #1;
        chk("mw2_StateOut", StateOut, 1);
        tick(); MemReadyM = 1; #1;
        chk("mwr_StateOut", StateOut, 1);
        chk("mwr_StallF", StallF, 0);
        chk("mwr_FlushW", FlushW, 0);
        chk("mwr_MemWaitCount", MemWaitCount, PERF ? 3 : 0);
        tick(); idle(); #1;
        chk("mw_back_StateOut", StateOut, 0);

        // request and ready together, with a branch: no wait
        tick(); MemReqM = 1; MemReadyM = 1; PCSelectE = 1; #1;
        chk("rr_StallF", StallF, 0);
        chk("rr_FlushD", FlushD, 1);
        tick(); idle(); #1;
        chk("rr_StateOut", StateOut, 0);

        // timeout: entry + TO wait cycles, then ERROR
        tick(); MemReqM = 1; #1;
        for (int i = 1; i <= TO; i++) begin
            tick(); #1;
            chk("to_wait_StateOut", StateOut, 1);
        end
        tick(); idle(); MemReadyM = 1; #1;
        chk("to_err_StateOut", StateOut, 2);
        chk("to_MemTimeout", MemTimeout, 1);
        chk("to_StallE", StallE, 1);
        tick(); #1;
        chk("to_hold_FlushW", FlushW, 1);

        // reset from ERROR
        tick(); reset = 1; #1;
        chk("rstE_StallF", StallF, 0);
        tick(); reset = 0; idle(); #1;
        chk("rstE_MemTimeout", MemTimeout, 0);
        chk("rstE_StateOut", StateOut, 0);

        // reset in the middle of a wait
        tick(); MemReqM = 1; #1;
        tick(); tick(); #1;
        chk("rstW_pre_StateOut", StateOut, 1);
        reset = 1; #1;
        chk("rstW_during_StateOut", StateOut, 0);
        chk("rstW_during_StallM", StallM, 0);
        tick(); reset = 0; idle(); #1;
        chk("rstW_StateOut", StateOut, 0);
        chk("rstW_StallF", StallF, 0);
        chk("rstW_MemWaitCount", MemWaitCount, 0);
        chk("rstW_LoadUseCount", LoadUseCount, 0);

        tick(); tick();
        mon_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
